// File: rtl/clint_pkg.sv
// clint_pkg: shared constants, FSM encoding and byte-lane helper for the CLINT.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clint_pkg;

   // Word offsets decoded from adr_i[4:2]
   localparam logic [2:0] MSIP        = 3'd0;
   localparam logic [2:0] MTIMECMP_LO = 3'd2;
   localparam logic [2:0] MTIMECMP_HI = 3'd3;
   localparam logic [2:0] MTIME_LO    = 3'd4;
   localparam logic [2:0] MTIME_HI    = 3'd5;

   // mtimecmp resets to all ones so the timer interrupt stays quiet until programmed
   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   // Replace only the byte lanes selected by sel
   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/clint_mtime.sv
// clint_mtime: prescaler plus 64-bit mtime counter with byte-lane writable halves.
// Latency: a write is visible on mtime_o the next cycle; increments every TICK_DIVIDER cycles.
// Backpressure: none; writes are accepted every cycle they are presented.
// Ports: clk_i/rst_i (sync, active-high), we_lo_i/we_hi_i per-half write enables,
//        sel_i byte lanes, wdata_i write data, mtime_o current counter value.
module clint_mtime
   import clint_pkg::*;
#(
   parameter int TICK_DIVIDER = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_lo_i,
   input  logic        we_hi_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] mtime_o
);

   localparam logic [15:0] PRESC_MAX = 16'(TICK_DIVIDER - 1);

   logic [15:0] presc_q, presc_d;
   logic [63:0] mtime_q, mtime_d;
   logic        tick;

   always_comb begin
      tick    = (presc_q == PRESC_MAX);
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
      mtime_d = mtime_q;
      // A write to either half suppresses this cycle's increment for the whole
      // counter; the prescaler keeps running regardless.
      if (we_lo_i || we_hi_i) begin
         if (we_lo_i) mtime_d[31:0]  = byte_merge(mtime_q[31:0],  wdata_i, sel_i);
         if (we_hi_i) mtime_d[63:32] = byte_merge(mtime_q[63:32], wdata_i, sel_i);
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         presc_q <= 16'd0;
         mtime_q <= 64'd0;
      end else begin
         presc_q <= presc_d;
         mtime_q <= mtime_d;
      end
   end

   assign mtime_o = mtime_q;

endmodule

// File: rtl/clint.sv
// clint: strobe/ack bus responder holding msip, mtimecmp and mtime; drives timer/software irqs.
// Latency: ack_o one cycle after stb_i is sampled in IDLE; timer_interrupt registered (1 cycle).
// Backpressure: none; at most one access every 2 cycles, stb_i ignored while acking.
// Ports: clk_i, rst_i (sync, active-high); stb_i/we_i/adr_i/data_i/sel_i request;
//        data_o/ack_o response; timer_interrupt, software_interrupt to the core.
module clint
   import clint_pkg::*;
#(
   parameter int TICK_DIVIDER = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [31:0] adr_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  sel_i,
   output logic [31:0] data_o,
   output logic        ack_o,
   output logic        timer_interrupt,
   output logic        software_interrupt
);

   state_t      state_q, state_d;
   logic        ack_q, ack_d;
   logic [31:0] data_q, data_d;
   logic        msip_q, msip_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        tint_q, tint_d;

   logic [2:0]  off;
   logic        wr;
   logic        mt_we_lo, mt_we_hi;
   logic [63:0] mtime;
   logic [31:0] rd_val;
   logic        unused_adr;

   assign off        = adr_i[4:2];
   assign unused_adr = ^{adr_i[31:5], adr_i[1:0]};

   // Accesses only start in IDLE; the strobe still high during ACK belongs to
   // the access already being acknowledged.
   assign wr       = (state_q == IDLE) && stb_i && we_i;
   assign mt_we_lo = wr && (off == MTIME_LO);
   assign mt_we_hi = wr && (off == MTIME_HI);

   clint_mtime #(
      .TICK_DIVIDER (TICK_DIVIDER)
   ) u_mtime (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_lo_i (mt_we_lo),
      .we_hi_i (mt_we_hi),
      .sel_i   (sel_i),
      .wdata_i (data_i),
      .mtime_o (mtime)
   );

   always_comb begin
      rd_val = 32'd0;
      case (off)
         MSIP:        rd_val = {31'd0, msip_q};
         MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
         MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
         MTIME_LO:    rd_val = mtime[31:0];
         MTIME_HI:    rd_val = mtime[63:32];
         default:     rd_val = 32'd0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      ack_d      = 1'b0;
      data_d     = 32'd0;
      msip_d     = msip_q;
      mtimecmp_d = mtimecmp_q;
      tint_d     = (mtime >= mtimecmp_q);

      case (state_q)
         IDLE: begin
            if (stb_i) begin
               state_d = ACK;
               ack_d   = 1'b1;
               if (!we_i) data_d = rd_val;
            end
         end
         ACK: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (wr) begin
         case (off)
            MSIP:        if (sel_i[0]) msip_d = data_i[0];
            MTIMECMP_LO: mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0],  data_i, sel_i);
            MTIMECMP_HI: mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], data_i, sel_i);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         ack_q      <= 1'b0;
         data_q     <= 32'd0;
         msip_q     <= 1'b0;
         mtimecmp_q <= MTIMECMP_RST;
         tint_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         data_q     <= data_d;
         msip_q     <= msip_d;
         mtimecmp_q <= mtimecmp_d;
         tint_q     <= tint_d;
      end
   end

   assign ack_o              = ack_q;
   assign data_o             = data_q;
   assign timer_interrupt    = tint_q;
   assign software_interrupt = msip_q;

endmodule

// File: doc/clint.md
# clint

Memory-mapped machine timer and software-interrupt responder for the core's single-master bus. It is the responder end of the core's strobe/acknowledge bus: it decodes word accesses, acknowledges each one, and holds the RISC-V mtime, mtimecmp and msip registers. It drives the core's `timer_interrupt` and `software_interrupt` inputs. A bus decoder upstream gates `stb_i`, so every strobe this block sees targets it.

## Interface
- `TICK_DIVIDER`, default 1: number of `clk_i` cycles per mtime increment; legal range 1..65535.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `stb_i`  in  1  access request; held by the initiator until it samples `ack_o`.
- `we_i`  in  1  1 = write, 0 = read.
- `adr_i`  in  32  byte address; only `adr_i[4:2]` is decoded.
- `data_i`  in  32  write data.
- `sel_i`  in  4  byte-lane enables for writes; `sel_i[n]` covers `data_i[8n+7:8n]`.
- `data_o`  out  32  read data; valid while `ack_o` is 1, 0 otherwise.
- `ack_o`  out  1  one-cycle acknowledge.
- `timer_interrupt`  out  1  registered result of mtime ≥ mtimecmp.
- `software_interrupt`  out  1  msip bit 0.

## Operation
- Register map, by word offset `adr_i[4:2]`:
  - 0 = msip. Only bit 0 is stored; other bits read 0.
  - 2 = mtimecmp[31:0].
  - 3 = mtimecmp[63:32].
  - 4 = mtime[31:0].
  - 5 = mtime[63:32].
  - 1, 6, 7: reads return 0, writes are ignored, and the access is still acked.
- Bus FSM states: IDLE and ACK.
  - IDLE with `stb_i` = 1: perform the access, move to ACK.
  - ACK: always returns to IDLE. `stb_i` is ignored in ACK because it is still high from the current access.
- Writes:
  - Committed at the IDLE→ACK edge.
  - Each byte is written only where `sel_i` is set; `sel_i` = 0 is a legal no-op write.
- Reads:
  - `data_o` is loaded at the IDLE→ACK edge with the register value before any same-edge update.
  - `data_o` is cleared on leaving ACK.
- mtime:
  - 64-bit counter with a prescaler that counts 0..`TICK_DIVIDER`−1.
  - mtime increments by 1 when the prescaler wraps, and wraps from 2^64−1 to 0.
  - A bus write to either mtime half overrides that cycle's increment for the whole counter. The prescaler keeps running.
- Compare:
  - `timer_interrupt` is a flop loaded every cycle with the unsigned 64-bit comparison mtime ≥ mtimecmp, using the current register values.
  - It is level-sensitive. It is cleared only when software raises mtimecmp or lowers mtime.
- Software reads the 64-bit mtime as hi, lo, hi and retries on a mismatch. The block gives no atomic 64-bit snapshot.
- Reset values:
  - `ack_o` = 0, `data_o` = 0, FSM in IDLE.
  - msip = 0, mtime = 0, prescaler = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - `timer_interrupt` = 0, `software_interrupt` = 0.
- Reset mid-access: if `rst_i` is high in an access cycle, no write is committed, the FSM goes to IDLE and `ack_o` is 0 in the next cycle. A strobe still held after reset is then served as a new access.

## Timing
- Access latency: `stb_i` sampled high in cycle N gives `ack_o` = 1 in cycle N+1 only. Back-to-back accesses are acked at most every 2 cycles.
- The written value is visible to a read whose strobe is sampled in cycle N+2 or later.
- `software_interrupt` follows an msip write in cycle N+1.
- `timer_interrupt` timing:
  - It rises 1 cycle after the edge at which mtime ≥ mtimecmp first holds.
  - After a mtimecmp or mtime write committed at edge N→N+1, it reflects the new comparison from cycle N+2.
- With `TICK_DIVIDER` = 1, mtime increments every cycle. With `TICK_DIVIDER` = D, it increments every D cycles, counted from the end of reset.

## Structure
- Package `clint_pkg` holds:
  - the word-offset constants `MSIP`, `MTIMECMP_LO`, `MTIMECMP_HI`, `MTIME_LO`, `MTIME_HI`;
  - the FSM enum `state_t` with values IDLE and ACK;
  - the mtimecmp reset constant.
- Sub-module `clint_mtime` contains the prescaler and the 64-bit counter. Its inputs are a write-enable per half, byte-lane enables and write data; its output is mtime.
- `clint` contains the bus FSM, the address decode, msip, mtimecmp and the compare flop.

## Test plan
- Reset with `TICK_DIVIDER` = 1, then read offset 4 twice, 2 cycles apart. Each `ack_o` arrives 1 cycle after its strobe, and the second value exceeds the first by 2. Both interrupt outputs are 0.
- Write 32'h1 to msip with `sel_i` = 4'hF → `software_interrupt` = 1 one cycle later. Write 0 → it drops. A read of msip after writing 32'hFFFF_FFFF returns 32'h1.
- Write mtimecmp_hi = 0 and mtimecmp_lo = 32'h40 with mtime near 0 → `timer_interrupt` rises exactly 1 cycle after mtime reaches 32'h40. Writing mtimecmp_hi = 32'hFFFF_FFFF clears it 2 cycles after the write's strobe.
- Write mtime_lo = 32'hFFFF_FFFF with `sel_i` = 4'b0011 starting from mtime = 0 → mtime = 32'h0000_FFFF in the cycle after the write; counting then resumes. Set the low half to all ones → the carry propagates into mtime_hi.
- Hold `stb_i` high for 2 cycles with a write to mtimecmp_lo → exactly one `ack_o` pulse and exactly one commit. A reset asserted in the strobe cycle gives no ack and leaves the register unchanged.
- With `TICK_DIVIDER` = 3, mtime advances by 1 every 3 cycles. An access to an unmapped offset (word offset 6) is acked and reads 32'h0.
